// File: rtl/uc_fsm_stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : uc_pkg                                                           |
// | Purpose : Shared definitions for the uc_fsm_stack control unit: opcode     |
// |           encodings and match patterns, RUN/WAIT state encoding, and the   |
// |           helper that sizes the OUT-port index fields.                     |
// | Ports   : none (package)                                                   |
// | Config  : UC_STACK_GUARD_EN is consumed by ret_stack, not by this package. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package uc_pkg;

   // Wildcard patterns, used with casez ('?' = don't care)
   localparam logic [5:0] OP_ALU     = 6'b??0???;
   localparam logic [5:0] OP_LOAD    = 6'b??1000;
   localparam logic [5:0] OP_OUT_IND = 6'b??1111;

   // Exact opcodes
   localparam logic [5:0] OP_JMP     = 6'b001001;
   localparam logic [5:0] OP_JZ      = 6'b001010;
   localparam logic [5:0] OP_JNZ     = 6'b001011;
   localparam logic [5:0] OP_IN      = 6'b001100;
   localparam logic [5:0] OP_OUT_REG = 6'b001101;
   localparam logic [5:0] OP_OUT_IMM = 6'b001110;
   localparam logic [5:0] OP_REL     = 6'b011001;
   localparam logic [5:0] OP_CALL    = 6'b011010;
   localparam logic [5:0] OP_RET     = 6'b011011;
   localparam logic [5:0] OP_PLOAD   = 6'b011100;
   localparam logic [5:0] OP_PSTART  = 6'b011101;
   localparam logic [5:0] OP_PCFG    = 6'b011110;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } uc_state_e;

   // Width of an OUT-port index field; never narrower than one bit.
   function automatic int port_w(input int n_ports);
      return (n_ports <= 2) ? 1 : $clog2(n_ports);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uc_fsm_stack_ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ret_stack                                                        |
// | Purpose : Return-address stack for CALL/RET. Push writes mem[sp] and bumps |
// |           sp; pop decrements sp; top_o is a combinational read of         |
// |           mem[sp-1]. Contents are not cleared on reset.                    |
// | Ports   : clk, reset (sync, active-high), push_i, pop_i, data_i[PC_W],     |
// |           top_o[PC_W], err_o (sticky fault)                                |
// | Config  : UC_STACK_GUARD_EN - overflow/underflow suppressed and flagged,   |
// |           top_o=0 when empty. Undefined: sp wraps mod STACK_DEPTH, err_o=0.|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ret_stack #(
   parameter int  PC_W        = 10,
   parameter int  STACK_DEPTH = 4,
   localparam int SP_W        = $clog2(STACK_DEPTH) + 1,
   localparam int IDX_W       = $clog2(STACK_DEPTH)
)(
   input  logic            clk,
   input  logic            reset,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] data_i,
   output logic [PC_W-1:0] top_o,
   output logic            err_o
);

   logic [PC_W-1:0]  mem_q [STACK_DEPTH];
   logic [SP_W-1:0]  sp_q, sp_d;
   logic [IDX_W-1:0] wr_idx, top_idx;
   logic             do_push;

   // Depth is a power of two, so the low sp bits address the array directly
   // and the subtraction wraps naturally to the last entry.
   assign wr_idx  = sp_q[IDX_W-1:0];
   assign top_idx = wr_idx - IDX_W'(1);

`ifdef UC_STACK_GUARD_EN
   logic full, empty, err_q, err_d;

   assign full  = (sp_q == SP_W'(STACK_DEPTH));
   assign empty = (sp_q == '0);

   always_comb begin
      sp_d    = sp_q;
      err_d   = err_q;
      do_push = 1'b0;
      if (push_i) begin
         if (full) begin
            err_d = 1'b1;
         end else begin
            do_push = 1'b1;
            sp_d    = sp_q + SP_W'(1);
         end
      end else if (pop_i) begin
         if (empty) begin
            err_d = 1'b1;
         end else begin
            sp_d = sp_q - SP_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
   assign top_o = empty ? '0 : mem_q[top_idx];
`else
   // Unguarded: sp stays within 0..STACK_DEPTH-1, overwriting the oldest
   // entry on overflow and returning stale entries on underflow.
   always_comb begin
      sp_d    = sp_q;
      do_push = push_i;
      if (push_i) begin
         sp_d = (sp_q == SP_W'(STACK_DEPTH - 1)) ? '0 : sp_q + SP_W'(1);
      end else if (pop_i) begin
         sp_d = (sp_q == '0) ? SP_W'(STACK_DEPTH - 1) : sp_q - SP_W'(1);
      end
   end

   assign err_o = 1'b0;
   assign top_o = mem_q[top_idx];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uc_fsm_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uc_fsm_stack                                                     |
// | Purpose : CPU control unit. Decodes a 6-bit opcode into datapath selects,  |
// |           one-hot output-port enables and peripheral strobes; owns a       |
// |           return-address stack for CALL/RET and a RUN/WAIT FSM that stalls |
// |           the PC while a started peripheral is busy.                       |
// | Ports   : clk, reset (sync, active-high); opcode_i, z_i, port_a_i,         |
// |           port_b_i, pc_plus1_i, per_done_i in; alu_op_o, datapath selects, |
// |           pc_en_o, port_en_o[N_PORTS], per_load/start/cfg_o, ret_addr_o,   |
// |           stack_err_o out.                                                 |
// | Config  : UC_STACK_GUARD_EN enables stack overflow/underflow protection.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uc_fsm_stack
   import uc_pkg::*;
#(
   parameter int  N_PORTS     = 4,
   parameter int  PC_W        = 10,
   parameter int  STACK_DEPTH = 4,
   localparam int PORT_W      = port_w(N_PORTS)
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode_i,
   input  logic               z_i,
   input  logic [PORT_W-1:0]  port_a_i,
   input  logic [PORT_W-1:0]  port_b_i,
   input  logic [PC_W-1:0]    pc_plus1_i,
   input  logic               per_done_i,
   output logic [2:0]         alu_op_o,
   output logic               we3_o,
   output logic               s_inm_o,
   output logic               s_inc_o,
   output logic               s_rel_o,
   output logic               s_ret_o,
   output logic               selentrada_o,
   output logic               selsalida_o,
   output logic               pc_en_o,
   output logic [N_PORTS-1:0] port_en_o,
   output logic               per_load_o,
   output logic               per_start_o,
   output logic               per_cfg_o,
   output logic [PC_W-1:0]    ret_addr_o,
   output logic               stack_err_o
);

   uc_state_e         state_q, state_d;
   logic              port_req;
   logic [PORT_W-1:0] port_idx;
   logic              stk_push, stk_pop;

   assign alu_op_o = opcode_i[2:0];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (opcode_i == OP_PSTART) state_d = ST_WAIT;
         ST_WAIT: if (per_done_i)            state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   // Output decode
   always_comb begin
      we3_o        = 1'b0;
      s_inm_o      = 1'b0;
      s_inc_o      = 1'b1;
      s_rel_o      = 1'b0;
      s_ret_o      = 1'b0;
      selentrada_o = 1'b0;
      selsalida_o  = 1'b0;
      pc_en_o      = 1'b1;
      per_load_o   = 1'b0;
      per_start_o  = 1'b0;
      per_cfg_o    = 1'b0;
      port_req     = 1'b0;
      port_idx     = port_a_i;
      stk_push     = 1'b0;
      stk_pop      = 1'b0;

      if (reset) begin
         // Hold the PC while reset is asserted; the FSM is forced back to RUN.
         pc_en_o = 1'b0;
      end else if (state_q == ST_WAIT) begin
         // Opcode is ignored; release the PC on the completion cycle only.
         pc_en_o = per_done_i;
      end else begin
         casez (opcode_i)
            OP_ALU:     we3_o = 1'b1;
            OP_LOAD:    begin we3_o = 1'b1; s_inm_o = 1'b1; end
            OP_JMP:     s_inc_o = 1'b0;
            OP_JZ:      s_inc_o = ~z_i;
            OP_JNZ:     s_inc_o = z_i;
            OP_IN:      begin we3_o = 1'b1; selentrada_o = 1'b1; end
            OP_OUT_REG: begin selsalida_o = 1'b1; port_req = 1'b1; end
            OP_OUT_IMM: port_req = 1'b1;
            OP_OUT_IND: begin
               selsalida_o = 1'b1;
               port_req    = 1'b1;
               port_idx    = port_b_i;
            end
            OP_REL:     s_rel_o = 1'b1;
            OP_CALL:    begin s_inc_o = 1'b0; stk_push = 1'b1; end
            OP_RET:     begin s_inc_o = 1'b0; s_ret_o = 1'b1; stk_pop = 1'b1; end
            OP_PLOAD:   per_load_o = 1'b1;
            OP_PCFG:    per_cfg_o = 1'b1;
            OP_PSTART:  begin per_start_o = 1'b1; pc_en_o = 1'b0; end
            default:    ;
         endcase
      end
   end

   // One-hot port enable; an index beyond the port count selects nothing.
   always_comb begin
      port_en_o = '0;
      if (port_req && (int'(port_idx) < N_PORTS)) begin
         port_en_o[port_idx] = 1'b1;
      end
   end

   ret_stack #(
      .PC_W        (PC_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ret_stack (
      .clk    (clk),
      .reset  (reset),
      .push_i (stk_push),
      .pop_i  (stk_pop),
      .data_i (pc_plus1_i),
      .top_o  (ret_addr_o),
      .err_o  (stack_err_o)
   );

endmodule
`default_nettype wire
